spi_sensor_responder: RTL
=========================

SPI_SENSOR_RESPONDER -- requirements
Module: spi_sensor_responder

Interface
REQ-001 Parameter DATA_W, default 16, frame length in bits (both directions).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk, cs_n and mosi.
REQ-003 clk  input  1  system clock; all logic is in this single domain.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sample_data  input  DATA_W  sensor word to be returned on the next frame.
REQ-006 sample_wr  input  1  single-cycle strobe that writes sample_data into the shadow register.
REQ-007 sclk  input  1  SPI clock from initiator, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-008 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-009 mosi  input  1  SPI data from initiator, MSB first.
REQ-010 miso  output  1  SPI data to initiator, MSB first.
REQ-011 miso_oe  output  1  miso drive enable; high only while selected.
REQ-012 rx_data  output  DATA_W  last complete word received on mosi.
REQ-013 frame_done  output  1  one-cycle pulse when a full frame completes.
REQ-014 frame_abort  output  1  one-cycle pulse when cs_n deasserts mid-frame.
REQ-015 underrun  output  1  one-cycle pulse when a frame starts with no fresh sample.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 sclk, cs_n and mosi shall each pass through SYNC_STAGES flops; edges shall be detected on synchronized values with one extra history flop.
REQ-018 The FSM shall have states IDLE, LOAD, SHIFT, DONE.
REQ-019 IDLE -> LOAD on a detected cs_n falling edge; no other IDLE exit.
REQ-020 LOAD (one cycle) shall copy the shadow register into tx_shift, clear rx_shift and the bit counter, drive miso = shadow MSB, and assert miso_oe; -> SHIFT.
REQ-021 LOAD shall pulse underrun if the fresh flag is 0; the same frame shall still send the held shadow value.
REQ-022 In SHIFT, on each sclk rising edge, the synchronized mosi shall shift into rx_shift LSB and the bit counter shall increment.
REQ-023 In SHIFT, on each sclk falling edge, tx_shift shall shift left and miso shall present the new MSB; no shift shall occur on the falling edge following the final bit.
REQ-024 When the counter reaches DATA_W on a rising edge -> DONE; DONE (one cycle) shall load rx_data from rx_shift and pulse frame_done; -> IDLE if cs_n is high, else remain in a hold sub-condition of IDLE-wait, ignoring further sclk edges until cs_n rises.
REQ-025 A cs_n rising edge in LOAD or SHIFT shall pulse frame_abort, leave rx_data unchanged, and return to IDLE next cycle.
REQ-026 miso_oe shall deassert within one cycle of a synchronized cs_n rising edge; miso shall be 0 whenever miso_oe is low.
REQ-027 sample_wr shall update the shadow register and set fresh = 1 in any state; LOAD clears fresh.
REQ-028 If sample_wr and LOAD coincide, tx_shift gets the old shadow, the shadow gets the new value, and fresh ends at 1.
REQ-029 The bit counter shall be $clog2(DATA_W)+1 bits wide and shall never wrap within a frame.
REQ-030 Correct operation requires each sclk half period to be at least SYNC_STAGES+2 clk cycles.

Reset
REQ-031 Reset shall force: state IDLE, miso 0, miso_oe 0, rx_data 0, shadow 0, fresh 0, all pulses 0, busy 0, and synchronizers to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-032 Reset asserted mid-frame shall abort silently with no frame_abort pulse; after release, the block shall wait for a new cs_n falling edge.

Structure
REQ-033 The state enum and default DATA_W shall reside in the shared package spi_pkg, reusable by the SPI initiator side.
REQ-034 The synchronizer plus edge detector shall be a sub-module named sync_edge, instantiated three times (edge outputs unused for mosi).

Verification
REQ-035 sample_wr with 0xA5C3, then a 16-bit frame with mosi 0x8001 -> miso bits 1010010111000011, rx_data 0x8001, one frame_done, no underrun.
REQ-036 Two frames with no sample_wr between them -> the second frame repeats 0xA5C3 and pulses underrun once at its LOAD.
REQ-037 cs_n raised after 7 bits -> frame_abort pulse, rx_data keeps its prior value, miso_oe low within SYNC_STAGES+2 cycles, and the next full frame is correct.
REQ-038 sample_wr 0x1234 in the same cycle as LOAD (held 0xA5C3) -> the frame sends 0xA5C3, the next frame sends 0x1234 without underrun.
REQ-039 rst pulsed during bit 9 -> all outputs take reset values, no frame_done or frame_abort, and the following frame with 0x0F0F is received correctly.
REQ-040 17 sclk pulses with cs_n low -> exactly one frame_done, the extra edge is ignored, and rx_data equals the first 16 bits.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions for the initiator and responder sides
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synchronized level
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      hist <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_sensor_responder.sv
// rtl/spi_sensor_responder.sv - SPI mode-0 responder returning a host-written sensor sample
module spi_sensor_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_wr,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun,
  output logic              busy
);

  localparam int CNT_W    = $clog2(DATA_W) + 1;
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    LAST_IDX   = CNT_W'(DATA_W - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e          state, state_nx;
  logic [DATA_W-1:0]   shadow, tx_shift, rx_shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                fresh, armed, settled;
  logic                do_load, do_rx, do_tx, do_abort;

  // The synchronizer reset level fakes a deselected bus; only trust a cs_n fall
  // once real samples have flushed through and cs_n has been seen high.
  assign settled = (settle_cnt == SETTLE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_load  = 1'b0;
    do_rx    = 1'b0;
    do_tx    = 1'b0;
    do_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall && armed) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        do_load = 1'b1;
        if (cs_rise) begin
          do_abort = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          do_abort = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          do_rx = sclk_rise;
          do_tx = sclk_fall && (bit_cnt != '0);
          if (sclk_rise && (bit_cnt == LAST_IDX)) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      fresh       <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      miso_oe     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      settle_cnt  <= '0;
      armed       <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= do_abort;
      underrun    <= 1'b0;

      if (!settled) settle_cnt <= settle_cnt + SETTLE_W'(1);
      if (settled && cs_q) armed <= 1'b1;

      // A write landing on LOAD wins over the LOAD clear of fresh.
      if (sample_wr) begin
        shadow <= sample_data;
        fresh  <= 1'b1;
      end else if (do_load) begin
        fresh  <= 1'b0;
      end

      if (do_load) begin
        tx_shift <= shadow;
        rx_shift <= '0;
        bit_cnt  <= '0;
        underrun <= ~fresh;
      end
      if (do_rx) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_q};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (do_tx) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      if (state == ST_DONE) begin
        rx_data    <= rx_shift;
        frame_done <= 1'b1;
      end

      if (cs_q || do_abort) miso_oe <= 1'b0;
      else if (do_load)     miso_oe <= 1'b1;
    end
  end

  assign miso = miso_oe & tx_shift[DATA_W-1];
  assign busy = (state != ST_IDLE);

endmodule
